// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, opcodes, next-PC selects and fetch FSM encodings
package proc_pkg;
   localparam int PC_W    = 6;
   localparam int INSTR_W = 20;
   localparam logic [3:0] OP_HALT  = 4'b0000;
   localparam logic [3:0] OP_RST   = 4'b0010;
   localparam logic [3:0] OP_WRITE = 4'b0011;
   localparam logic [3:0] OP_LOADI = 4'b0100;
   localparam logic [3:0] OP_MUL   = 4'b0101;
   localparam logic [3:0] OP_LOAD  = 4'b0110;
   localparam logic [3:0] OP_MV    = 4'b0111;
   localparam logic [3:0] OP_ADD   = 4'b1000;
   localparam logic [3:0] OP_INC   = 4'b1001;
   localparam logic [3:0] OP_SUB   = 4'b1010;
   localparam logic [3:0] OP_JMPZ  = 4'b1011;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_STORE = 4'b1101;
   localparam logic [1:0] PCSEL_HOLD = 2'b00;
   localparam logic [1:0] PCSEL_INC  = 2'b01;
   localparam logic [1:0] PCSEL_JMP  = 2'b10;
   localparam logic [1:0] PCSEL_HALT = 2'b11;
   // BOOT is the reset state: it keeps iram_re low while reset is held and
   // launches the automatic fetch of address 0 on the first clock after release.
   localparam logic [2:0] S_BOOT  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;
   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4];
   endfunction
endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with hold, wrapping increment and load
module program_counter
   import proc_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inc_i,
   input  logic            load_i,
   input  logic [PC_W-1:0] load_val_i,
   output logic [PC_W-1:0] pc_o
);
   logic [PC_W-1:0] pc_q, pc_d;
   // load wins over increment; increment wraps at 2^PC_W
   always_comb pc_d = load_i ? load_val_i : inc_i ? pc_q + PC_W'(1) : pc_q;
   // PC register
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) pc_q <= '0;
      else pc_q <= pc_d;
   assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads the IRAM and presents instructions to the control unit
module instr_fetch_unit
   import proc_pkg::*;
#(
   parameter int IRAM_LAT = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               fetch_req_i,
   input  logic [1:0]         pc_sel_i,
   input  logic [PC_W-1:0]    gamma_i,
   output logic [PC_W-1:0]    iram_addr_o,
   output logic               iram_re_o,
   input  logic [INSTR_W-1:0] iram_rdata_i,
   output logic [INSTR_W-1:0] instruction_o,
   output logic               instr_valid_o,
   output logic [PC_W-1:0]    pc_o,
   output logic               busy_o,
   output logic               halted_o
);
   logic [2:0]         state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               valid_q, valid_d, halted_q, halted_d;
   logic               accept, pc_inc, pc_load;
   logic [PC_W-1:0]    pc;

   assign accept  = state_q == S_HOLD && fetch_req_i;
   assign pc_inc  = accept && pc_sel_i == PCSEL_INC;
   assign pc_load = accept && pc_sel_i == PCSEL_JMP;

   program_counter u_pc (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (pc_inc),
      .load_i     (pc_load),
      .load_val_i (gamma_i),
      .pc_o       (pc)
   );

   // fetch sequencing: issue, count down the IRAM latency, latch IR, then hold or halt
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ir_d     = ir_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      case (state_q)
         S_BOOT:  state_d = S_ISSUE;
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = 2'(IRAM_LAT - 1);
         end
         S_WAIT:
            if (cnt_q == 2'd0) begin
               ir_d     = iram_rdata_i;
               valid_d  = 1'b1;
               halted_d = opcode_of(iram_rdata_i) == OP_HALT;
               state_d  = halted_d ? S_HALT : S_HOLD;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         S_HOLD:
            if (fetch_req_i && pc_sel_i != PCSEL_HOLD) begin
               valid_d  = 1'b0;
               halted_d = pc_sel_i == PCSEL_HALT;
               state_d  = halted_d ? S_HALT : S_ISSUE;
            end
         default: ;
      endcase
   end

   // state, latency counter and instruction register; reset aborts any read in flight
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q  <= S_BOOT;
         cnt_q    <= '0;
         ir_q     <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ir_q     <= ir_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end

   assign iram_addr_o   = pc;
   assign iram_re_o     = state_q == S_ISSUE;
   assign busy_o        = state_q == S_ISSUE || state_q == S_WAIT;
   assign instruction_o = ir_q;
   assign instr_valid_o = valid_q;
   assign pc_o          = pc;
   assign halted_o      = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven and scoreboarded checks of the fetch unit at IRAM latencies 1 and 3
module tb_instr_fetch_unit;
   import proc_pkg::*;

   typedef struct {
      logic [1:0]      sel;
      logic [PC_W-1:0] gamma;
      logic [PC_W-1:0] exp_pc;
      bit              fetch;
   } vec_t;

   typedef struct {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               halted;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   exp_t sb[$];
   vec_t vecs[7];
   logic [INSTR_W-1:0] mem [64];

   logic rst1_n = 1'b0, req1 = 1'b0, re1, val1, busy1, halt1;
   logic [1:0] sel1 = 2'b00;
   logic [PC_W-1:0] gam1 = '0, addr1, pc1;
   logic [INSTR_W-1:0] rd1 = '0, ins1;

   logic rst3_n = 1'b0, req3 = 1'b0, re3, val3, busy3, halt3;
   logic [1:0] sel3 = 2'b00;
   logic [PC_W-1:0] gam3 = '0, addr3, pc3;
   logic [INSTR_W-1:0] rd3, ins3;
   logic [INSTR_W-1:0] p3 [3];

   instr_fetch_unit #(.IRAM_LAT(1)) u1 (
      .clk_i(clk), .rst_ni(rst1_n), .fetch_req_i(req1), .pc_sel_i(sel1), .gamma_i(gam1),
      .iram_addr_o(addr1), .iram_re_o(re1), .iram_rdata_i(rd1), .instruction_o(ins1),
      .instr_valid_o(val1), .pc_o(pc1), .busy_o(busy1), .halted_o(halt1)
   );

   instr_fetch_unit #(.IRAM_LAT(3)) u3 (
      .clk_i(clk), .rst_ni(rst3_n), .fetch_req_i(req3), .pc_sel_i(sel3), .gamma_i(gam3),
      .iram_addr_o(addr3), .iram_re_o(re3), .iram_rdata_i(rd3), .instruction_o(ins3),
      .instr_valid_o(val3), .pc_o(pc3), .busy_o(busy3), .halted_o(halt3)
   );

   function automatic logic [INSTR_W-1:0] mem_val(input int a);
      if (a == 0) return 20'h81200;
      if (a == 'h30) return 20'h00030;
      return {4'h9 + 4'(a % 4), 4'h0, 6'(a), 6'(a ^ 'h15)};
   endfunction

   // behavioural IRAMs; idle cycles return a poison word so mistimed latches show up
   always @(posedge clk) rd1 <= re1 ? mem[addr1] : 20'hEEEEE;
   always @(posedge clk) begin
      p3[0] <= re3 ? mem[addr3] : 20'hEEEEE;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign rd3 = p3[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every rising instr_valid on the latency-1 unit consumes one expectation
   logic pv1 = 1'b0;
   always @(negedge clk) begin
      if (val1 && !pv1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got instr %0h expected none", ins1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pc", 32'(pc1), 32'(e.pc));
            chk("sb_instr", 32'(ins1), 32'(e.instr));
            chk("sb_halted", 32'(halt1), 32'(e.halted));
         end
      end
      pv1 = val1;
   end

   task automatic wait_hold1(input string name);
      int n = 0;
      while (!(val1 && !busy1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(val1 && !busy1), 32'd1);
   endtask

   task automatic apply(input vec_t v);
      int n;
      logic [INSTR_W-1:0] ir0;
      logic [PC_W-1:0] pc0;
      wait_hold1("hold_ready");
      ir0 = ins1;
      pc0 = pc1;
      if (v.fetch) sb.push_back('{v.exp_pc, mem_val(int'(v.exp_pc)), opcode_of(mem_val(int'(v.exp_pc))) == OP_HALT});
      req1 = 1'b1;
      sel1 = v.sel;
      gam1 = v.gamma;
      @(negedge clk);
      req1 = 1'b0;
      gam1 = 6'($urandom);
      chk("re_after_accept", 32'(re1), 32'(v.fetch));
      if (v.fetch) begin
         chk("addr_after_accept", 32'(addr1), 32'(v.exp_pc));
         n = 1;
         while (!val1 && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("latency", 32'(n), 32'd3);
         chk("pc", 32'(pc1), 32'(v.exp_pc));
      end else begin
         repeat (3) begin
            chk("hold_no_re", 32'(re1), 32'd0);
            @(negedge clk);
         end
         chk("hold_pc", 32'(pc1), 32'(pc0));
         chk("hold_ir", 32'(ins1), 32'(ir0));
         chk("hold_valid", 32'(val1), 32'd1);
      end
   endtask

   task automatic poke_halted(input logic [1:0] s, input logic [PC_W-1:0] g, input logic [PC_W-1:0] pc_exp);
      req1 = 1'b1;
      sel1 = s;
      gam1 = g;
      @(negedge clk);
      req1 = 1'b0;
      repeat (3) begin
         chk("halt_no_re", 32'(re1), 32'd0);
         chk("halt_pc", 32'(pc1), 32'(pc_exp));
         chk("halt_sticky", 32'(halt1), 32'd1);
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 64; a++) mem[a] = mem_val(a);
      vecs[0] = '{PCSEL_JMP,  6'h05, 6'h05, 1'b1};
      vecs[1] = '{PCSEL_INC,  6'h11, 6'h06, 1'b1};
      vecs[2] = '{PCSEL_JMP,  6'h3F, 6'h3F, 1'b1};
      vecs[3] = '{PCSEL_INC,  6'h00, 6'h00, 1'b1};
      vecs[4] = '{PCSEL_HOLD, 6'h22, 6'h00, 1'b0};
      vecs[5] = '{PCSEL_INC,  6'h3F, 6'h01, 1'b1};
      vecs[6] = '{PCSEL_JMP,  6'h30, 6'h30, 1'b1};
      repeat (2) @(negedge clk);
      chk("rst_pc", 32'(pc1), 32'd0);
      chk("rst_ir", 32'(ins1), 32'd0);
      chk("rst_valid", 32'(val1), 32'd0);
      chk("rst_re", 32'(re1), 32'd0);
      chk("rst_addr", 32'(addr1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_halted", 32'(halt1), 32'd0);
      sb.push_back('{6'd0, 20'h81200, 1'b0});
      rst1_n = 1'b1;
      @(negedge clk);
      chk("boot_re", 32'(re1), 32'd1);
      chk("boot_addr", 32'(addr1), 32'd0);
      chk("boot_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("boot_c2_valid", 32'(val1), 32'd0);
      chk("boot_c2_re", 32'(re1), 32'd0);
      @(negedge clk);
      chk("boot_c3_valid", 32'(val1), 32'd1);
      chk("boot_c3_instr", 32'(ins1), 32'h81200);
      for (int i = 0; i < 6; i++) apply(vecs[i]);
      // jump to 0x2A with a second request held through ISSUE and WAIT
      wait_hold1("t3_ready");
      sb.push_back('{6'h2A, mem_val('h2A), 1'b0});
      req1 = 1'b1;
      sel1 = PCSEL_JMP;
      gam1 = 6'h2A;
      @(negedge clk);
      chk("jmp_re", 32'(re1), 32'd1);
      chk("jmp_addr", 32'(addr1), 32'h2A);
      sel1 = PCSEL_INC;
      gam1 = 6'h00;
      @(negedge clk);
      chk("drop_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      req1 = 1'b0;
      chk("drop_valid", 32'(val1), 32'd1);
      chk("drop_pc", 32'(pc1), 32'h2A);
      @(negedge clk);
      chk("drop_no_re", 32'(re1), 32'd0);
      chk("drop_pc2", 32'(pc1), 32'h2A);
      // HALT opcode on IR load
      apply(vecs[6]);
      chk("halt_op_halted", 32'(halt1), 32'd1);
      chk("halt_op_valid", 32'(val1), 32'd1);
      poke_halted(PCSEL_INC, 6'h07, 6'h30);
      poke_halted(PCSEL_JMP, 6'h05, 6'h30);
      // reset, then halt through pc_sel=11
      rst1_n = 1'b0;
      #1;
      chk("rst2_halted", 32'(halt1), 32'd0);
      chk("rst2_pc", 32'(pc1), 32'd0);
      chk("rst2_valid", 32'(val1), 32'd0);
      chk("sb_empty_at_reset", 32'(sb.size()), 32'd0);
      @(negedge clk);
      sb.push_back('{6'd0, 20'h81200, 1'b0});
      rst1_n = 1'b1;
      wait_hold1("t4b_ready");
      req1 = 1'b1;
      sel1 = PCSEL_HALT;
      @(negedge clk);
      req1 = 1'b0;
      chk("sel11_halted", 32'(halt1), 32'd1);
      chk("sel11_valid", 32'(val1), 32'd0);
      chk("sel11_re", 32'(re1), 32'd0);
      chk("sel11_busy", 32'(busy1), 32'd0);
      poke_halted(PCSEL_INC, 6'h09, 6'h00);
      // latency 3: boot fetch, then reset during WAIT
      rst3_n = 1'b1;
      @(negedge clk);
      chk("l3_boot_re", 32'(re3), 32'd1);
      chk("l3_boot_addr", 32'(addr3), 32'd0);
      repeat (3) @(negedge clk);
      chk("l3_c4_valid", 32'(val3), 32'd0);
      @(negedge clk);
      chk("l3_c5_valid", 32'(val3), 32'd1);
      chk("l3_c5_instr", 32'(ins3), 32'h81200);
      req3 = 1'b1;
      sel3 = PCSEL_JMP;
      gam3 = 6'h11;
      @(negedge clk);
      req3 = 1'b0;
      chk("l3_jmp_re", 32'(re3), 32'd1);
      chk("l3_jmp_addr", 32'(addr3), 32'h11);
      @(negedge clk);
      chk("l3_wait_busy", 32'(busy3), 32'd1);
      rst3_n = 1'b0;
      #1;
      chk("l3_rst_pc", 32'(pc3), 32'd0);
      chk("l3_rst_ir", 32'(ins3), 32'd0);
      chk("l3_rst_valid", 32'(val3), 32'd0);
      chk("l3_rst_re", 32'(re3), 32'd0);
      chk("l3_rst_addr", 32'(addr3), 32'd0);
      chk("l3_rst_busy", 32'(busy3), 32'd0);
      chk("l3_rst_halted", 32'(halt3), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("l3_stale_valid", 32'(val3), 32'd0);
         chk("l3_stale_ir", 32'(ins3), 32'd0);
      end
      rst3_n = 1'b1;
      @(negedge clk);
      chk("l3_refetch_re", 32'(re3), 32'd1);
      chk("l3_refetch_addr", 32'(addr3), 32'd0);
      repeat (4) @(negedge clk);
      chk("l3_refetch_valid", 32'(val3), 32'd1);
      chk("l3_refetch_instr", 32'(ins3), 32'h81200);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
